// File: rtl/ps2_tecla_pkg.sv
// ps2_tecla_pkg: scancodes, key codes, FSM encodings and the scancode-to-key map
package ps2_tecla_pkg;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] K_W      = 8'h57;
    localparam logic [7:0] K_S      = 8'h53;
    localparam logic [7:0] K_A      = 8'h65;
    localparam logic [7:0] K_D      = 8'h68;
    localparam logic [7:0] K_ENTER  = 8'h0D;
    localparam logic [7:0] K_SPACE  = 8'h20;
    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {DEC_NORMAL, DEC_EXT, DEC_BREAK, DEC_EXT_BREAK} dec_state_t;
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] code;
    } key_map_t;
    function automatic key_map_t map_key(input logic [7:0] sc);
        case (sc)
            SC_W:     map_key = '{1'b1, 3'd0, K_W};
            SC_S:     map_key = '{1'b1, 3'd1, K_S};
            SC_A:     map_key = '{1'b1, 3'd2, K_A};
            SC_D:     map_key = '{1'b1, 3'd3, K_D};
            SC_ENTER: map_key = '{1'b1, 3'd4, K_ENTER};
            SC_SPACE: map_key = '{1'b1, 3'd5, K_SPACE};
            default:  map_key = '0;
        endcase
    endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes/filters PS/2 lines and receives 11-bit frames into checked bytes
module ps2_rx_frame
    import ps2_tecla_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [1:0] clk_sync, data_sync;
    logic [FILTER_LEN-1:0] hist;
    logic filt, fall, timeout, ok;
    logic [10:0] sr;
    logic [3:0] cnt;
    logic [TW-1:0] tcnt;
    rx_state_t state, state_nx;
    // filtered level only moves once the whole history agrees
    assign fall = filt && hist == '0;
    assign timeout = state == RX_SHIFT && !fall && tcnt == TW'(TIMEOUT_CYC - 1);
    assign ok = !sr[0] && sr[10] && ^sr[9:1];
    assign rx_byte = sr[8:1];
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            hist      <= '1;
            filt      <= 1'b1;
            sr        <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            state     <= RX_IDLE;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            hist      <= {hist[FILTER_LEN-2:0], clk_sync[1]};
            filt      <= &hist ? 1'b1 : ~|hist ? 1'b0 : filt;
            state     <= state_nx;
            if (fall && state != RX_CHECK)
                sr <= {data_sync[1], sr[10:1]};
            cnt  <= (state_nx != RX_SHIFT) ? 4'd0 : fall ? cnt + 4'd1 : cnt;
            tcnt <= (fall || state != RX_SHIFT) ? '0 : tcnt + 1'b1;
        end
    end
    always_comb begin
        state_nx   = state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state)
            RX_IDLE:  state_nx = fall ? RX_SHIFT : RX_IDLE;
            RX_SHIFT: begin
                state_nx  = (fall && cnt == 4'd10) ? RX_CHECK : timeout ? RX_IDLE : RX_SHIFT;
                frame_err = timeout;
            end
            default: begin
                state_nx   = RX_IDLE;
                byte_valid = ok;
                frame_err  = !ok;
            end
        endcase
    end
endmodule

// File: rtl/ps2_tecla_irq.sv
// ps2_tecla_irq: PS/2 make-code decoder with held key and level interrupt; TECLA_REPEAT_FILTER_EN enables typematic repeat suppression
module ps2_tecla_irq
    import ps2_tecla_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       interrupt_ack,
    output logic [7:0] tecla,
    output logic       interrupt,
    output logic       overrun,
    output logic       frame_err
);
    logic byte_valid, accept;
    logic [7:0] rx_byte;
    key_map_t km;
    dec_state_t state, state_nx;
    ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .byte_valid(byte_valid),
        .rx_byte(rx_byte),
        .frame_err(frame_err)
    );
    assign km = map_key(rx_byte);
`ifdef TECLA_REPEAT_FILTER_EN
    logic [5:0] held;
    assign accept = byte_valid && state == DEC_NORMAL && km.hit && !held[km.idx];
    always_ff @(posedge clk) begin
        if (reset)
            held <= '0;
        else if (accept)
            held[km.idx] <= 1'b1;
        else if (byte_valid && state == DEC_BREAK && km.hit)
            held[km.idx] <= 1'b0;
    end
`else
    assign accept = byte_valid && state == DEC_NORMAL && km.hit;
`endif
    always_comb begin
        state_nx = state;
        if (byte_valid)
            case (state)
                DEC_NORMAL: state_nx = rx_byte == SC_BREAK ? DEC_BREAK : rx_byte == SC_EXT ? DEC_EXT : DEC_NORMAL;
                DEC_EXT:    state_nx = rx_byte == SC_BREAK ? DEC_EXT_BREAK : DEC_NORMAL;
                default:    state_nx = DEC_NORMAL;
            endcase
    end
    // an ack landing with a new key frees the slot first, so the key loads without overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DEC_NORMAL;
            tecla     <= 8'h00;
            interrupt <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            interrupt <= accept || (interrupt && !interrupt_ack);
            if (accept && (!interrupt || interrupt_ack))
                tecla <= km.code;
            if (accept && interrupt && !interrupt_ack)
                overrun <= 1'b1;
        end
    end
endmodule
